decod_enc: RTL and testbench

DECOD_ENC -- requirements
Module: decod_enc

---
 rtl/decod_enc.sv | 125 ++++++++++++
 tb/tb_decod_enc.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/decod_enc.sv
// decod_enc: scans a captured multi-hot line vector and presents one
// decoder select code per accepted handshake. It drives a 5-input
// (4 select + enable) 4-to-16 decoder whose select inputs are inverted.
module decod_enc #(
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] req,
  input  logic        load,
  input  logic        ready,
  output logic        enc0,
  output logic        enc1,
  output logic        enc2,
  output logic        enc3,
  output logic        enc4,
  output logic        busy,
  output logic        done,
  output logic [4:0]  cnt
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_EMIT = 1'b1;

  logic [0:0]  r_state;
  logic [15:0] r_pending;   // lines captured but not yet accepted downstream
  logic [3:0]  r_idx;       // index currently presented
  logic [3:0]  r_code;      // inverted index as seen by the decoder selects
  logic        r_valid;
  logic        r_done;
  logic [4:0]  r_cnt;

  logic [15:0] w_remaining;
  logic [3:0]  w_first_idx;
  logic [3:0]  w_next_idx;

  // First set index in the configured scan order; 0 when v is empty
  // (callers only use the result when v is non-zero).
  function automatic logic [3:0] first_idx(input logic [15:0] v);
    logic [3:0] idx;
    idx = 4'd0;
    if (LSB_FIRST) begin
      for (int i = 15; i >= 0; i--) begin
        if (v[i]) idx = i[3:0];
      end
    end else begin
      for (int i = 0; i < 16; i++) begin
        if (v[i]) idx = i[3:0];
      end
    end
    return idx;
  endfunction

  // Number of set bits; 5 bits so that 16 does not wrap.
  function automatic logic [4:0] popcount(input logic [15:0] v);
    logic [4:0] n;
    n = 5'd0;
    for (int i = 0; i < 16; i++) begin
      n = n + 5'(v[i]);
    end
    return n;
  endfunction

  assign w_remaining = r_pending & ~(16'd1 << r_idx);
  assign w_first_idx = first_idx(req);
  assign w_next_idx  = first_idx(w_remaining);

  // Scan controller: capture on load, advance one line per handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_pending <= 16'd0;
      r_idx     <= 4'd0;
      r_code    <= 4'd0;
      r_valid   <= 1'b0;
      r_done    <= 1'b0;
      r_cnt     <= 5'd0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values; blocking here would chain updates within one edge.
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (load) begin
            r_cnt <= popcount(req);
            if (req != 16'd0) begin
              r_pending <= req;
              r_idx     <= w_first_idx;
              r_code    <= ~w_first_idx;
              r_valid   <= 1'b1;
              r_state   <= S_EMIT;
            end else begin
              r_done <= 1'b1;
            end
          end
        end
        S_EMIT: begin
          if (ready) begin
            r_pending <= w_remaining;
            if (w_remaining != 16'd0) begin
              r_idx  <= w_next_idx;
              r_code <= ~w_next_idx;
            end else begin
              r_valid <= 1'b0;
              r_code  <= 4'd0;
              r_done  <= 1'b1;
              r_state <= S_IDLE;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign enc0 = r_code[3];
  assign enc1 = r_code[2];
  assign enc2 = r_code[1];
  assign enc3 = r_code[0];
  assign enc4 = r_valid;
  assign busy = (r_state == S_EMIT);
  assign done = r_done;
  assign cnt  = r_cnt;

endmodule

// File: tb/tb_decod_enc.sv
// Testbench for decod_enc: one ascending-scan and one descending-scan
// instance share stimulus; a queue-based model predicts every output.
module tb_decod_enc;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [15:0] req;
  logic        load;
  logic        ready;

  logic a_e0, a_e1, a_e2, a_e3, a_e4, a_busy, a_done;
  logic d_e0, d_e1, d_e2, d_e3, d_e4, d_busy, d_done;
  logic [4:0] a_cnt, d_cnt;
  logic [4:0] a_code, d_code;

  assign a_code = {a_e4, a_e0, a_e1, a_e2, a_e3};
  assign d_code = {d_e4, d_e0, d_e1, d_e2, d_e3};

  decod_enc #(.LSB_FIRST(1'b1)) u_asc (
    .clk(clk), .rst_n(rst_n), .req(req), .load(load), .ready(ready),
    .enc0(a_e0), .enc1(a_e1), .enc2(a_e2), .enc3(a_e3), .enc4(a_e4),
    .busy(a_busy), .done(a_done), .cnt(a_cnt)
  );

  decod_enc #(.LSB_FIRST(1'b0)) u_desc (
    .clk(clk), .rst_n(rst_n), .req(req), .load(load), .ready(ready),
    .enc0(d_e0), .enc1(d_e1), .enc2(d_e2), .enc3(d_e3), .enc4(d_e4),
    .busy(d_busy), .done(d_done), .cnt(d_cnt)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: indices still to be sent, in the order each
  // instance must present them.
  int          qa[$];
  int          qd[$];
  bit          e_done;
  logic [4:0]  e_cnt;
  logic [15:0] e_cap;
  logic [15:0] seen_a, seen_d;
  int          hs_a, hs_d;

  task automatic model_reset();
    qa.delete();
    qd.delete();
    e_done = 1'b0;
    e_cnt  = 5'd0;
    e_cap  = 16'd0;
    seen_a = 16'd0;
    seen_d = 16'd0;
    hs_a   = 0;
    hs_d   = 0;
  endtask

  task automatic model_step();
    if (!rst_n) begin
      model_reset();
    end else if (qa.size() != 0) begin
      e_done = 1'b0;
      if (ready) begin
        void'(qa.pop_front());
        void'(qd.pop_front());
        if (qa.size() == 0) e_done = 1'b1;
      end
    end else begin
      e_done = 1'b0;
      if (load) begin
        e_cnt  = 5'($countones(req));
        e_cap  = req;
        seen_a = 16'd0;
        seen_d = 16'd0;
        hs_a   = 0;
        hs_d   = 0;
        for (int i = 0; i < 16; i++) if (req[i]) qa.push_back(i);
        for (int i = 15; i >= 0; i--) if (req[i]) qd.push_back(i);
        if (req == 16'd0) e_done = 1'b1;
      end
    end
  endtask

  // Ideal decoder: the line selected by the presented code is ~select.
  task automatic record_handshakes();
    logic [3:0] k;
    if (rst_n && ready) begin
      if (a_e4) begin
        k = ~{a_e0, a_e1, a_e2, a_e3};
        seen_a[k] = 1'b1;
        hs_a++;
      end
      if (d_e4) begin
        k = ~{d_e0, d_e1, d_e2, d_e3};
        seen_d[k] = 1'b1;
        hs_d++;
      end
    end
  endtask

  task automatic compare();
    logic [4:0] ea, ed;
    int t;
    bit eb;
    ea = 5'd0;
    ed = 5'd0;
    if (qa.size() != 0) begin
      t  = qa[0];
      ea = {1'b1, ~t[3:0]};
      t  = qd[0];
      ed = {1'b1, ~t[3:0]};
    end
    eb = (qa.size() != 0);
    check("enc_asc", a_code, ea);
    check("enc_desc", d_code, ed);
    check("busy", {a_busy, d_busy}, {eb, eb});
    check("done", {a_done, d_done}, {e_done, e_done});
    check("cnt", {a_cnt, d_cnt}, {e_cnt, e_cnt});
    if (e_done) begin
      check("sb_lines_asc", seen_a, e_cap);
      check("sb_lines_desc", seen_d, e_cap);
      check("sb_count", {hs_a[7:0], hs_d[7:0]},
            {8'($countones(e_cap)), 8'($countones(e_cap))});
    end
  endtask

  // Called at a negedge: drive, clock, then check on the next negedge.
  task automatic step(input logic l, input logic [15:0] r, input logic rd);
    load  = l;
    req   = r;
    ready = rd;
    record_handshakes();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare();
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    #1;
    check("rst_async", {a_code, a_busy, a_done, a_cnt, d_code, d_busy, d_done, d_cnt}, 32'd0);
    model_reset();
    @(negedge clk);
    step(1'b0, 16'd0, 1'b0);
    rst_n = 1'b1;
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && qa.size() != 0; i++) step(1'b0, 16'd0, 1'b1);
    step(1'b0, 16'd0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    load  = 1'b0;
    req   = 16'd0;
    ready = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check("reset_state", {a_code, a_busy, a_done, a_cnt, d_code, d_busy, d_done, d_cnt}, 32'd0);
    rst_n = 1'b1;

    // Two-line scan, ready held high; req changed after capture.
    step(1'b1, 16'h0021, 1'b1);
    check("h21_k0", a_code, 5'b11111);
    step(1'b0, 16'h0000, 1'b1);
    check("h21_k5", a_code, 5'b11010);
    step(1'b0, 16'hFFFF, 1'b1);
    check("h21_done", {a_e4, a_done, a_cnt}, {2'b01, 5'd2});
    step(1'b0, 16'd0, 1'b0);

    // Same vector with ready toggling: each code holds until accepted.
    step(1'b1, 16'h0021, 1'b0);
    step(1'b0, 16'h1234, 1'b0);
    check("hold_k0", a_code, 5'b11111);
    step(1'b0, 16'h0000, 1'b1);
    step(1'b0, 16'h00FF, 1'b0);
    check("hold_k5", a_code, 5'b11010);
    step(1'b0, 16'h0000, 1'b1);
    step(1'b0, 16'h0000, 1'b0);

    // Empty load: done pulse only; then a load in the done cycle.
    step(1'b1, 16'h0000, 1'b1);
    check("empty_load", {a_busy, a_e4, a_done, a_cnt}, {3'b001, 5'd0});
    step(1'b1, 16'h0010, 1'b1);
    check("load_on_done", a_code, 5'b11011);
    drain();

    // All lines, with a load pulse mid-scan that must be ignored.
    step(1'b1, 16'hFFFF, 1'b1);
    check("ffff_cnt", a_cnt, 5'd16);
    for (int i = 1; i < 16; i++) step(i == 7, 16'h0003, 1'b1);
    step(1'b0, 16'd0, 1'b1);
    check("ffff_done", {a_done, a_cnt}, {1'b1, 5'd16});
    step(1'b0, 16'd0, 1'b0);

    // Descending order on the second instance.
    step(1'b1, 16'h8001, 1'b1);
    check("desc_k15", d_code, 5'b10000);
    step(1'b0, 16'd0, 1'b1);
    check("desc_k0", d_code, 5'b11111);
    drain();

    // Abort mid-scan with reset; nothing emitted until a new load.
    step(1'b1, 16'h0007, 1'b1);
    step(1'b0, 16'h0000, 1'b1);
    pulse_reset();
    for (int i = 0; i < 3; i++) step(1'b0, 16'h0007, 1'b1);
    check("post_rst_idle", {a_e4, d_e4}, 2'b00);
    pulse_reset();
    step(1'b1, 16'h0003, 1'b1);
    check("load_after_rst", a_code, 5'b11111);
    drain();

    // Random traffic.
    for (int n = 0; n < 600; n++) begin
      logic [15:0] r;
      case ($urandom_range(0, 4))
        0:       r = 16'd0;
        1:       r = 16'd1 << $urandom_range(0, 15);
        2:       r = 16'hFFFF;
        default: r = 16'($urandom);
      endcase
      if ($urandom_range(0, 99) == 0) pulse_reset();
      step($urandom_range(0, 3) == 0, r, $urandom_range(0, 2) != 0);
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
